// File: rtl/axi_ad9122_drp_arb.sv
`default_nettype none
// ============================================================================
// axi_ad9122_drp_arb : round-robin arbiter and single-access sequencer for the
// AD9122 MMCM DRP port, two requesters, up_clk domain.          Rev 1.0
// ============================================================================
module axi_ad9122_drp_arb #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hdeaddead
) (
  input  logic        up_clk,
  input  logic        up_rst,

  input  logic        req0_sel,
  input  logic        req0_wr,
  input  logic [11:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic [31:0] req0_rdata,
  output logic        req0_ready,
  output logic        req0_err,

  input  logic        req1_sel,
  input  logic        req1_wr,
  input  logic [11:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic [31:0] req1_rdata,
  output logic        req1_ready,
  output logic        req1_err,

  output logic        drp_sel,
  output logic        drp_wr,
  output logic [11:0] drp_addr,
  output logic [31:0] drp_wdata,
  input  logic [31:0] drp_rdata,
  input  logic        drp_ready,

  output logic        busy,
  output logic [7:0]  timeout_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [15:0] C_TIMEOUT  = 16'(TIMEOUT);
  localparam logic [7:0]  C_TCNT_MAX = 8'hff;

  state_t      state_q;
  logic        pend0_q, pend1_q;
  logic        last_grant_q, grant_q;
  logic        hold0_wr_q, hold1_wr_q;
  logic [11:0] hold0_addr_q, hold1_addr_q;
  logic [31:0] hold0_wdata_q, hold1_wdata_q;
  logic [15:0] wait_cnt_q;
  logic [7:0]  timeout_cnt_q;
  logic        busy_q;
  logic        drp_sel_q, drp_wr_q;
  logic [11:0] drp_addr_q;
  logic [31:0] drp_wdata_q;
  logic        req0_ready_q, req0_err_q;
  logic        req1_ready_q, req1_err_q;
  logic [31:0] req0_rdata_q, req1_rdata_q;

  logic        in_flight_d;
  logic        accept0_d, accept1_d;
  logic        grant_d;
  logic [15:0] wait_cnt_d;
  logic        timeout_d;
  logic [31:0] resp_data_d;
  logic        resp_err_d;

  // A requester that is pending or currently being served cannot queue a second access.
  always_comb begin
    in_flight_d = (state_q != ST_IDLE);
    accept0_d   = req0_sel & ~pend0_q & ~(in_flight_d & ~grant_q);
    accept1_d   = req1_sel & ~pend1_q & ~(in_flight_d &  grant_q);
    grant_d     = (pend0_q & pend1_q) ? ~last_grant_q : pend1_q;
    wait_cnt_d  = wait_cnt_q + 16'd1;
    timeout_d   = (wait_cnt_d == C_TIMEOUT);
    resp_data_d = drp_ready ? drp_rdata : ERR_DATA;
    resp_err_d  = ~drp_ready;
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      state_q       <= ST_IDLE;
      pend0_q       <= 1'b0;
      pend1_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      hold0_wr_q    <= 1'b0;
      hold0_addr_q  <= 12'h000;
      hold0_wdata_q <= 32'h0;
      hold1_wr_q    <= 1'b0;
      hold1_addr_q  <= 12'h000;
      hold1_wdata_q <= 32'h0;
      wait_cnt_q    <= 16'h0;
      timeout_cnt_q <= 8'h00;
      busy_q        <= 1'b0;
      drp_sel_q     <= 1'b0;
      drp_wr_q      <= 1'b0;
      drp_addr_q    <= 12'h000;
      drp_wdata_q   <= 32'h0;
      req0_ready_q  <= 1'b0;
      req0_err_q    <= 1'b0;
      req0_rdata_q  <= 32'h0;
      req1_ready_q  <= 1'b0;
      req1_err_q    <= 1'b0;
      req1_rdata_q  <= 32'h0;
    end else begin
      req0_ready_q <= 1'b0;
      req0_err_q   <= 1'b0;
      req1_ready_q <= 1'b0;
      req1_err_q   <= 1'b0;

      if (accept0_d) begin
        pend0_q       <= 1'b1;
        hold0_wr_q    <= req0_wr;
        hold0_addr_q  <= req0_addr;
        hold0_wdata_q <= req0_wdata;
      end
      if (accept1_d) begin
        pend1_q       <= 1'b1;
        hold1_wr_q    <= req1_wr;
        hold1_addr_q  <= req1_addr;
        hold1_wdata_q <= req1_wdata;
      end

      case (state_q)
        ST_IDLE: begin
          if (pend0_q || pend1_q) begin
            state_q      <= ST_ISSUE;
            busy_q       <= 1'b1;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            drp_sel_q    <= 1'b1;
            if (grant_d) begin
              pend1_q     <= 1'b0;
              drp_wr_q    <= hold1_wr_q;
              drp_addr_q  <= hold1_addr_q;
              drp_wdata_q <= hold1_wdata_q;
            end else begin
              pend0_q     <= 1'b0;
              drp_wr_q    <= hold0_wr_q;
              drp_addr_q  <= hold0_addr_q;
              drp_wdata_q <= hold0_wdata_q;
            end
          end
        end

        ST_ISSUE: begin
          state_q     <= ST_WAIT;
          wait_cnt_q  <= 16'h0;
          drp_sel_q   <= 1'b0;
          drp_wr_q    <= 1'b0;
          drp_addr_q  <= 12'h000;
          drp_wdata_q <= 32'h0;
        end

        // drp_ready takes priority over a timeout landing in the same cycle.
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_d;
          if (drp_ready || timeout_d) begin
            state_q <= ST_RESP;
            if (grant_q) begin
              req1_ready_q <= 1'b1;
              req1_err_q   <= resp_err_d;
              req1_rdata_q <= resp_data_d;
            end else begin
              req0_ready_q <= 1'b1;
              req0_err_q   <= resp_err_d;
              req0_rdata_q <= resp_data_d;
            end
            if (!drp_ready && (timeout_cnt_q != C_TCNT_MAX)) begin
              timeout_cnt_q <= timeout_cnt_q + 8'd1;
            end
          end
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req0_rdata  = req0_rdata_q;
  assign req0_ready  = req0_ready_q;
  assign req0_err    = req0_err_q;
  assign req1_rdata  = req1_rdata_q;
  assign req1_ready  = req1_ready_q;
  assign req1_err    = req1_err_q;
  assign drp_sel     = drp_sel_q;
  assign drp_wr      = drp_wr_q;
  assign drp_addr    = drp_addr_q;
  assign drp_wdata   = drp_wdata_q;
  assign busy        = busy_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_ad9122_drp_arb.sv
`default_nettype none
// tb_axi_ad9122_drp_arb : randomized bench; a DRP responder plus a queue-based
// model of grant order, response data, error flag and timeout count.
module tb_axi_ad9122_drp_arb;

  localparam int unsigned TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hdeaddead;

  logic        up_clk = 1'b0;
  logic        up_rst = 1'b1;
  logic        req0_sel = 1'b0, req0_wr = 1'b0;
  logic [11:0] req0_addr = 12'h0;
  logic [31:0] req0_wdata = 32'h0;
  logic [31:0] req0_rdata;
  logic        req0_ready, req0_err;
  logic        req1_sel = 1'b0, req1_wr = 1'b0;
  logic [11:0] req1_addr = 12'h0;
  logic [31:0] req1_wdata = 32'h0;
  logic [31:0] req1_rdata;
  logic        req1_ready, req1_err;
  logic        drp_sel, drp_wr;
  logic [11:0] drp_addr;
  logic [31:0] drp_wdata;
  logic [31:0] drp_rdata = 32'h0;
  logic        drp_ready = 1'b0;
  logic        busy;
  logic [7:0]  timeout_cnt;

  axi_ad9122_drp_arb #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .up_clk(up_clk), .up_rst(up_rst),
    .req0_sel(req0_sel), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_rdata(req0_rdata), .req0_ready(req0_ready), .req0_err(req0_err),
    .req1_sel(req1_sel), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_rdata(req1_rdata), .req1_ready(req1_ready), .req1_err(req1_err),
    .drp_sel(drp_sel), .drp_wr(drp_wr), .drp_addr(drp_addr), .drp_wdata(drp_wdata),
    .drp_rdata(drp_rdata), .drp_ready(drp_ready),
    .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 up_clk = ~up_clk;

  typedef struct { int unsigned delay; logic [31:0] data; } resp_t;
  typedef struct { logic wr; logic [11:0] addr; logic [31:0] wdata; int cyc; } acc_t;

  resp_t       rq[$];     // DRP responses, in the order accesses are expected
  acc_t        log_q[$];  // every drp_sel observed
  acc_t        last_acc;
  int          cyc = 0;
  int          countdown = 0;
  logic [31:0] pend_data = 32'h0;
  bit          outstanding = 1'b0;
  int          sel_overlap = 0;
  int          bus_bad = 0;
  int          checks = 0;
  int          failures = 0;
  int          m_last = 1;
  int          m_tcnt = 0;

  always @(posedge up_clk) cyc <= cyc + 1;

  // DRP device: answers delay cycles after drp_sel (delay 0 = never answers).
  always @(negedge up_clk) begin : p_drp
    resp_t r;
    drp_ready = 1'b0;
    drp_rdata = $urandom;
    if (up_rst === 1'b1 || req0_ready === 1'b1 || req1_ready === 1'b1) outstanding = 1'b0;
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        drp_ready = 1'b1;
        drp_rdata = pend_data;
      end
    end
    if (drp_sel !== 1'b1 && (drp_wr !== 1'b0 || drp_addr !== 12'h0 || drp_wdata !== 32'h0)) bus_bad++;
    if (drp_sel === 1'b1) begin
      if (outstanding) sel_overlap++;
      outstanding = 1'b1;
      log_q.push_back('{drp_wr, drp_addr, drp_wdata, cyc});
      if (rq.size() > 0) r = rq.pop_front();
      else r = '{0, 32'h0};
      countdown = int'(r.delay);
      pend_data = r.data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit s0, input bit s1,
                       input logic w0, input logic [11:0] a0, input logic [31:0] d0,
                       input logic w1, input logic [11:0] a1, input logic [31:0] d1,
                       output int sel_cyc);
    @(negedge up_clk);
    req0_sel = s0; req0_wr = w0; req0_addr = a0; req0_wdata = d0;
    req1_sel = s1; req1_wr = w1; req1_addr = a1; req1_wdata = d1;
    sel_cyc = cyc;
    @(negedge up_clk);
    req0_sel = 1'b0; req0_wr = 1'($urandom_range(0, 1)); req0_addr = 12'($urandom); req0_wdata = $urandom;
    req1_sel = 1'b0; req1_wr = 1'($urandom_range(0, 1)); req1_addr = 12'($urandom); req1_wdata = $urandom;
  endtask

  task automatic wait_done(output int who, output int at, output logic [31:0] rd0, output logic [31:0] rd1,
                           output logic e0, output logic e1);
    who = -1; at = -1; rd0 = 32'h0; rd1 = 32'h0; e0 = 1'b0; e1 = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) + 24; i++) begin
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        who = (req0_ready === 1'b1 && req1_ready === 1'b1) ? 2 : ((req1_ready === 1'b1) ? 1 : 0);
        at = cyc; rd0 = req0_rdata; rd1 = req1_rdata; e0 = req0_err; e1 = req1_err;
        return;
      end
      @(negedge up_clk);
    end
  endtask

  // Reference outcome of one access from the DRP response delay.
  task automatic model_expect(input int unsigned d, input logic [31:0] data,
                              output logic [31:0] rd, output logic err);
    if (d >= 1 && d <= TIMEOUT) begin
      rd = data; err = 1'b0;
    end else begin
      rd = ERR_DATA; err = 1'b1;
      m_tcnt = (m_tcnt < 255) ? m_tcnt + 1 : 255;
    end
  endtask

  task automatic complete(input string tag, input int exp_req, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                          output int at);
    int who;
    logic [31:0] rd0, rd1;
    logic e0, e1;
    wait_done(who, at, rd0, rd1, e0, e1);
    chk($sformatf("%s_who", tag), who, exp_req);
    chk($sformatf("%s_rdata", tag), (exp_req == 1) ? rd1 : rd0, exp_rd);
    chk($sformatf("%s_err", tag), 32'((exp_req == 1) ? e1 : e0), 32'(exp_err));
    chk($sformatf("%s_tcnt", tag), 32'(timeout_cnt), m_tcnt);
    chk($sformatf("%s_drp_count", tag), log_q.size(), 1);
    if (log_q.size() > 0) begin
      last_acc = log_q.pop_front();
      chk($sformatf("%s_drp_wr", tag), 32'(last_acc.wr), 32'(wr));
      chk($sformatf("%s_drp_addr", tag), 32'(last_acc.addr), 32'(addr));
      chk($sformatf("%s_drp_wdata", tag), last_acc.wdata, wdata);
    end
    @(negedge up_clk);
    chk($sformatf("%s_pulse", tag), 32'({req1_ready, req0_ready}), 32'h0);
    chk($sformatf("%s_hold", tag), (exp_req == 1) ? req1_rdata : req0_rdata, exp_rd);
  endtask

  // Random fields; grant order predicted from the round-robin rule.
  task automatic run_txn(input string tag, input bit s0, input bit s1,
                         input int unsigned d0, input int unsigned d1);
    logic        w[2];
    logic [11:0] a[2];
    logic [31:0] wd[2];
    logic [31:0] dd[2];
    int unsigned dl[2];
    int          order[$];
    int          sc, at, k;
    logic [31:0] rd;
    logic        er;
    dl[0] = d0; dl[1] = d1;
    for (int j = 0; j < 2; j++) begin
      w[j] = 1'($urandom_range(0, 1)); a[j] = 12'($urandom); wd[j] = $urandom; dd[j] = $urandom;
    end
    if (s0 && s1) begin
      order.push_back((m_last == 0) ? 1 : 0);
      order.push_back((m_last == 0) ? 0 : 1);
    end else if (s0) order.push_back(0);
    else if (s1) order.push_back(1);
    foreach (order[i]) rq.push_back('{dl[order[i]], dd[order[i]]});
    issue(s0, s1, w[0], a[0], wd[0], w[1], a[1], wd[1], sc);
    foreach (order[i]) begin
      k = order[i];
      m_last = k;
      model_expect(dl[k], dd[k], rd, er);
      complete($sformatf("%s%0d", tag, i), k, w[k], a[k], wd[k], rd, er, at);
    end
  endtask

  initial begin
    int sc, at, extra, pat;
    logic [31:0] rd;
    logic er;

    repeat (3) @(negedge up_clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_drp_sel", 32'(drp_sel), 32'h0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'h0);
    chk("rst_rdata0", req0_rdata, 32'h0);
    chk("rst_rdata1", req1_rdata, 32'h0);
    chk("rst_tcnt", 32'(timeout_cnt), 32'h0);
    up_rst = 1'b0;
    @(negedge up_clk);
    chk("idle_busy", 32'(busy), 32'h0);

    // both at once after reset: requester 0 first
    run_txn("sim", 1'b1, 1'b1, 2, 4);

    // single read, DRP answers 3 cycles after drp_sel
    rq.push_back('{3, 32'h0000_1234});
    issue(1'b1, 1'b0, 1'b0, 12'h008, 32'h0, 1'b0, 12'h0, 32'h0, sc);
    m_last = 0;
    complete("rd", 0, 1'b0, 12'h008, 32'h0, 32'h0000_1234, 1'b0, at);
    chk("rd_issue_cyc", last_acc.cyc - sc, 2);
    chk("rd_latency", at - sc, 6);

    // both pending after requester 0 was last: requester 1 first
    run_txn("alt", 1'b1, 1'b1, 1, 1);

    // DRP never answers
    rq.push_back('{0, 32'h0});
    issue(1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0a5, 32'h0, sc);
    m_last = 1;
    model_expect(0, 32'h0, rd, er);
    complete("tmo", 1, 1'b0, 12'h0a5, 32'h0, rd, er, at);
    chk("tmo_latency", at - sc, int'(TIMEOUT) + 3);
    chk("tmo_cnt", 32'(timeout_cnt), 32'h1);

    // ready in exactly the timeout cycle
    rq.push_back('{TIMEOUT, 32'h0000_00ff});
    issue(1'b1, 1'b0, 1'b1, 12'h123, 32'h5a5a_0001, 1'b0, 12'h0, 32'h0, sc);
    m_last = 0;
    complete("race", 0, 1'b1, 12'h123, 32'h5a5a_0001, 32'h0000_00ff, 1'b0, at);
    chk("race_latency", at - sc, int'(TIMEOUT) + 3);
    chk("race_cnt", 32'(timeout_cnt), 32'h1);

    // re-request from requester 0 while it is in WAIT is dropped
    rq.push_back('{6, 32'h0bad_f00d});
    issue(1'b1, 1'b0, 1'b0, 12'h044, 32'h0, 1'b0, 12'h0, 32'h0, sc);
    @(negedge up_clk);
    issue(1'b1, 1'b0, 1'b1, 12'h3ff, 32'hffff_ffff, 1'b0, 12'h0, 32'h0, sc);
    m_last = 0;
    complete("rereq", 0, 1'b0, 12'h044, 32'h0, 32'h0bad_f00d, 1'b0, at);
    extra = 0;
    repeat (10) begin
      @(negedge up_clk);
      if (req0_ready === 1'b1 || req1_ready === 1'b1) extra++;
    end
    chk("rereq_extra_ready", extra, 0);
    chk("rereq_extra_drp", log_q.size(), 0);
    chk("rereq_busy", 32'(busy), 32'h0);

    // randomized patterns and DRP delays (including timeouts and late readies)
    for (int i = 0; i < 40; i++) begin
      pat = int'($urandom_range(0, 2));
      run_txn($sformatf("rnd%0d_", i), pat != 1, pat != 0,
              $urandom_range(0, TIMEOUT + 3), $urandom_range(0, TIMEOUT + 3));
    end

    // reset while in WAIT, DRP answers after reset release
    rq.push_back('{6, 32'hcafe_0001});
    issue(1'b0, 1'b1, 1'b0, 12'h0, 32'h0, 1'b1, 12'h777, 32'h1111_2222, sc);
    repeat (2) @(negedge up_clk);
    up_rst = 1'b1;
    repeat (2) @(negedge up_clk);
    up_rst = 1'b0;
    m_last = 1;
    m_tcnt = 0;
    extra = 0;
    repeat (10) begin
      @(negedge up_clk);
      if (req0_ready === 1'b1 || req1_ready === 1'b1) extra++;
    end
    chk("rstw_no_ready", extra, 0);
    chk("rstw_busy", 32'(busy), 32'h0);
    chk("rstw_drp_sel", 32'(drp_sel), 32'h0);
    chk("rstw_rdata0", req0_rdata, 32'h0);
    chk("rstw_rdata1", req1_rdata, 32'h0);
    chk("rstw_tcnt", 32'(timeout_cnt), 32'h0);
    chk("rstw_drp_count", log_q.size(), 1);
    log_q.delete();
    run_txn("post_rst", 1'b1, 1'b1, 1, 2);

    // timeout counter saturation
    for (int i = 0; i < 300; i++) run_txn("sat", (i % 2) == 0, (i % 2) == 1, 0, 0);
    chk("sat_cnt", 32'(timeout_cnt), 32'hff);

    repeat (TIMEOUT + 5) @(negedge up_clk);
    chk("no_overlap_sel", sel_overlap, 0);
    chk("drp_bus_idle_zero", bus_bad, 0);
    chk("drp_log_empty", log_q.size(), 0);
    chk("resp_queue_empty", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
